// File: rtl/ifu_fetch.sv
// Single-outstanding RV32 instruction fetch: owns the PC, issues word requests,
// holds one instruction for decode, and honours execute-stage redirects.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [6:0]  out_op,
  output logic        out_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned INST_B = 4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   req_pc_q;
  logic [XLEN-1:0]   inst_q;
  logic              err_q;
  logic              drop_q;
  logic              req_valid_q;
  logic              out_valid_q;

  logic              req_fire_c;
  logic              rsp_fire_c;
  logic [XLEN-1:0]   redirect_tgt_c;

  // req_valid_q is only ever set while in REQ, so it doubles as the state qualifier.
  assign req_fire_c     = req_valid_q & imem_req_ready;
  assign rsp_fire_c     = (state_q == ST_WAIT) & imem_rsp_valid;
  assign redirect_tgt_c = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_REQ: begin
          // Valid rises one cycle after reset releases and stays up until accepted.
          req_valid_q <= 1'b1;
          if (req_fire_c) begin
            req_pc_q    <= fetch_pc_q;
            req_valid_q <= 1'b0;
            drop_q      <= redirect_valid;
            state_q     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (rsp_fire_c) begin
            if (drop_q || redirect_valid) begin
              drop_q      <= 1'b0;
              req_valid_q <= 1'b1;
              state_q     <= ST_REQ;
            end else begin
              inst_q      <= imem_rsp_data;
              err_q       <= imem_rsp_err;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A redirect squashes the held instruction even if decode is ready.
          if (redirect_valid || out_ready) begin
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b1;
            state_q     <= ST_REQ;
            if (!redirect_valid) begin
              fetch_pc_q <= req_pc_q + XLEN'(INST_B);
            end
          end
        end

        default: begin
          state_q     <= ST_REQ;
          drop_q      <= 1'b0;
          req_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase

      if (redirect_valid) begin
        fetch_pc_q <= redirect_tgt_c;
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = req_pc_q;
  assign out_inst       = inst_q;
  assign out_op         = inst_q[OP_W-1:0];
  assign out_err        = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: randomized memory/decode/redirect traffic
// checked against a transaction-level fetch model, plus directed scenarios.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_op;
  logic        out_err;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_op         (out_op),
    .out_err        (out_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus knobs
  int lat_min = 1, lat_max = 1;
  int ready_pct = 100, oready_pct = 100, redir_pct = 0, spur_pct = 0;
  int force_oready = -1;
  bit force_redir = 1'b0;
  logic [31:0] force_tgt = '0;

  // Reference model: next PC decode should see, expected valids, one outstanding slot
  logic [31:0] exp_pc = RESET_PC;
  bit          m_rv = 1'b0, m_ov = 1'b0;
  bit          outstanding = 1'b0, stale = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          ev_acc = 1'b0;
  int          dut_cons = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[4:2] == 3'd5;
  endfunction

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step();
    bit rsp_now, red, acc, cons, oready, rdy, drop_rsp, next_rv, next_ov;
    logic [31:0] tgt, w;
    checks++;
    if (imem_req_valid !== m_rv) begin
      errors++; $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, m_rv);
    end
    checks++;
    if (out_valid !== m_ov) begin
      errors++; $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, m_ov);
    end
    if (m_rv) begin
      checks++;
      if (imem_req_addr !== exp_pc) begin
        errors++; $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, exp_pc);
      end
    end
    if (m_ov) begin
      w = mem_word(exp_pc);
      checks++;
      if (out_pc !== exp_pc) begin
        errors++; $display("FAIL out_pc cyc=%0d got=%h want=%h", cyc, out_pc, exp_pc);
      end
      checks++;
      if (out_inst !== w) begin
        errors++; $display("FAIL out_inst cyc=%0d got=%h want=%h", cyc, out_inst, w);
      end
      checks++;
      if (out_op !== w[6:0]) begin
        errors++; $display("FAIL out_op cyc=%0d got=%h want=%h", cyc, out_op, w[6:0]);
      end
      checks++;
      if (out_err !== mem_err(exp_pc)) begin
        errors++; $display("FAIL out_err cyc=%0d got=%b want=%b", cyc, out_err, mem_err(exp_pc));
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1 && redirect_valid === 1'b0) dut_cons++;

    rsp_now = 1'b0;
    if (outstanding) begin
      pend_cnt--;
      rsp_now = (pend_cnt == 0);
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(pend_addr) : $urandom;
    imem_rsp_err   = rsp_now ? mem_err(pend_addr) : 1'($urandom);
    if (!outstanding && $urandom_range(99) < spur_pct) imem_rsp_valid = 1'b1;
    rdy    = ($urandom_range(99) < ready_pct);
    oready = (force_oready >= 0) ? force_oready[0] : ($urandom_range(99) < oready_pct);
    red    = force_redir || ($urandom_range(99) < redir_pct);
    tgt    = force_redir ? force_tgt : $urandom;
    force_redir    = 1'b0;
    imem_req_ready = rdy;
    out_ready      = oready;
    redirect_valid = red;
    redirect_pc    = tgt;

    acc      = m_rv && rdy;
    cons     = m_ov && oready && !red;
    drop_rsp = rsp_now && (stale || red);
    ev_acc   = acc;
    next_rv  = (m_rv && !acc) || drop_rsp || (m_ov && (oready || red));
    next_ov  = (m_ov && !oready && !red) || (rsp_now && !drop_rsp);
    if (rsp_now) begin
      outstanding = 1'b0;
      stale       = 1'b0;
    end
    if (acc) begin
      outstanding = 1'b1;
      pend_cnt    = $urandom_range(lat_max, lat_min);
      pend_addr   = exp_pc;
      stale       = red;
    end else if (outstanding && red) begin
      stale = 1'b1;
    end
    if (cons) exp_pc = exp_pc + 32'd4;
    if (red) exp_pc = {tgt[31:2], 2'b00};
    m_rv = next_rv;
    m_ov = next_ov;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input bit late_rsp);
    rst            = 1'b1;
    imem_rsp_valid = late_rsp;
    imem_rsp_data  = 32'h0000_006F;
    imem_rsp_err   = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) begin
      @(negedge clk); cyc++;
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL rst_req_valid cyc=%0d got=%b want=0", cyc, imem_req_valid);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_out_valid cyc=%0d got=%b want=0", cyc, out_valid);
      end
    end
    rst = 1'b0;
    @(negedge clk); cyc++;
    imem_rsp_valid = 1'b0;
    exp_pc      = RESET_PC;
    m_rv        = 1'b1;
    m_ov        = 1'b0;
    outstanding = 1'b0;
    stale       = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0 || out_op !== 7'h0 || out_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs pc=%h inst=%h op=%h err=%b want all 0", out_pc, out_inst, out_op, out_err);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_first_req valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    int n = 0, nacc = 0, acc_c = -100, prev_acc = -100;
    logic [31:0] a;
    logic v;
    lat_min = 1; lat_max = 1; ready_pct = 100; force_oready = 1; redir_pct = 0; spur_pct = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      a = imem_req_addr; v = imem_req_valid;
      step();
      if (v === 1'b1) begin
        checks++;
        if (a !== RESET_PC + 32'(4 * nacc)) begin
          errors++; $display("FAIL seq_addr got=%h want=%h", a, RESET_PC + 32'(4 * nacc));
        end
        prev_acc = acc_c; acc_c = cyc - 1;
        if (nacc > 0) begin
          checks++;
          if (acc_c - prev_acc != 3) begin
            errors++; $display("FAIL seq_rate got=%0d want=3 cycles", acc_c - prev_acc);
          end
        end
        nacc++;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (cyc - acc_c != 2) begin
          errors++; $display("FAIL seq_latency got=%0d want=2", cyc - acc_c);
        end
        checks++;
        if (out_pc !== RESET_PC + 32'(4 * n)) begin
          errors++; $display("FAIL seq_pc got=%h want=%h", out_pc, RESET_PC + 32'(4 * n));
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL seq_timeout got=%0d want=3 instructions", n);
    end
  endtask

  task automatic test_stall();
    logic [31:0] hp;
    lat_min = 1; lat_max = 3; force_oready = 0;
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_timeout got=%b want=1", out_valid);
    end
    hp = exp_pc;
    repeat (5) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== hp || out_inst !== mem_word(hp) || imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold ov=%b pc=%h inst=%h rv=%b want 1/%h/%h/0",
                           out_valid, out_pc, out_inst, imem_req_valid, hp, mem_word(hp));
      end
    end
    force_oready = 1;
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== hp + 32'd4) begin
      errors++; $display("FAIL stall_release rv=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, hp + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    bit got = 1'b0, bad_ov = 1'b0;
    logic [31:0] a = '0;
    lat_min = 3; lat_max = 3; force_oready = 1;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = ev_acc; end
    force_redir = 1'b1; force_tgt = 32'h8000_1002;
    step();
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      a = imem_req_addr; got = (imem_req_valid === 1'b1);
      if (out_valid === 1'b1) bad_ov = 1'b1;
      step();
    end
    checks++;
    if (!got || a !== 32'h8000_1000) begin
      errors++; $display("FAIL rwait_addr got=%h want=80001000", a);
    end
    checks++;
    if (bad_ov) begin
      errors++; $display("FAIL rwait_stale got=out_valid want=no out_valid");
    end
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_1000) begin
      errors++; $display("FAIL rwait_deliver ov=%b pc=%h want 1/80001000", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect_hold();
    lat_min = 1; lat_max = 2; force_oready = 0;
    for (int i = 0; i < 30 && out_valid !== 1'b1; i++) step();
    force_oready = 1; force_redir = 1'b1; force_tgt = 32'h8000_2000;
    step();
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_2000) begin
      errors++; $display("FAIL rhold_squash ov=%b rv=%b addr=%h want 0/1/80002000", out_valid, imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 30 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_pc !== 32'h8000_2000) begin
      errors++; $display("FAIL rhold_pc got=%h want=80002000", out_pc);
    end
  endtask

  task automatic test_redirect_rsp();
    bit got = 1'b0;
    int nacc = 0;
    logic v;
    lat_min = 2; lat_max = 2; force_oready = 1;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = ev_acc; end
    step();
    force_redir = 1'b1; force_tgt = 32'h8000_3000;
    step();
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_3000) begin
      errors++; $display("FAIL rrsp_discard ov=%b rv=%b addr=%h want 0/1/80003000", out_valid, imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
      v = imem_req_valid; step();
      if (v === 1'b1) nacc++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_3000 || nacc != 1) begin
      errors++; $display("FAIL rrsp_nodrop ov=%b pc=%h reqs=%0d want 1/80003000/1", out_valid, out_pc, nacc);
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 3; force_oready = 0;
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFE;
    step();
    for (int i = 0; i < 30 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_pc ov=%b pc=%h want 1/fffffffc", out_valid, out_pc);
    end
    force_oready = 1;
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next rv=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_err();
    lat_min = 1; lat_max = 3; force_oready = 0;
    force_redir = 1'b1; force_tgt = 32'h8000_0014;
    step();
    for (int i = 0; i < 30 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0014 || out_err !== 1'b1) begin
      errors++; $display("FAIL err_set ov=%b pc=%h err=%b want 1/80000014/1", out_valid, out_pc, out_err);
    end
    force_oready = 1;
    step();
    force_oready = 0;
    for (int i = 0; i < 30 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0018 || out_err !== 1'b0) begin
      errors++; $display("FAIL err_clear ov=%b pc=%h err=%b want 1/80000018/0", out_valid, out_pc, out_err);
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    lat_min = 3; lat_max = 3; force_oready = 0;
    force_oready = 1;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = ev_acc; end
    force_oready = 0;
    do_reset(1'b1);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_wait rv=%b addr=%h ov=%b want 1/%h/0", imem_req_valid, imem_req_addr, out_valid, RESET_PC);
    end
    for (int i = 0; i < 30 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
      errors++; $display("FAIL rmid_fetch ov=%b pc=%h want 1/%h", out_valid, out_pc, RESET_PC);
    end
    do_reset(1'b1);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_hold rv=%b addr=%h ov=%b want 1/%h/0", imem_req_valid, imem_req_addr, out_valid, RESET_PC);
    end
  endtask

  task automatic test_random();
    int c0;
    lat_min = 1; lat_max = 4; ready_pct = 70; oready_pct = 60; redir_pct = 8; spur_pct = 20;
    force_oready = -1;
    c0 = dut_cons;
    repeat (3000) step();
    checks++;
    if (dut_cons - c0 < 100) begin
      errors++; $display("FAIL random_progress got=%0d want>=100 consumed", dut_cons - c0);
    end
    ready_pct = 100; redir_pct = 0; spur_pct = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_rsp();
    test_wrap();
    test_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Single-outstanding instruction fetch unit for the RV32 core. It owns the PC, issues word requests to instruction memory over a valid/ready request channel, captures the response, and presents one instruction at a time to the decode stage, including the opcode field that drives the immediate-type decoder. Redirects from execute (jal, jalr, taken branch, trap or CSR return) override sequential fetch and squash any in-flight or held instruction.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid (one per accepted request).
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  access fault for this response.
- out_valid  out  1  instruction held for decode.
- out_ready  in  1  decode consumes this cycle.
- out_pc  out  32  PC of held instruction.
- out_inst  out  32  held instruction word.
- out_op  out  7  out_inst[6:0], to the immediate-type decoder.
- out_err  out  1  held instruction carries an access fault.
- redirect_valid  in  1  PC redirect from execute.
- redirect_pc  in  32  redirect target; bits [1:0] are cleared internally.

## Operation
- Registers: fetch_pc, req_pc, inst/err holding register, state, drop flag.
- States: REQ (imem_req_valid=1, addr=fetch_pc), WAIT (one request outstanding), HOLD (out_valid=1).
- REQ: on req_valid&req_ready: req_pc<=fetch_pc, ->WAIT. Address may change while valid is high and not yet accepted (bus permits it).
- WAIT: on rsp_valid: if drop=0 capture data/err, ->HOLD; if drop=1 discard, clear drop, ->REQ.
- HOLD: on out_valid&out_ready&~redirect_valid: fetch_pc<=req_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), ->REQ. out_pc/out_inst/out_err stable until then.
- Redirect (priority over all sequential updates), target T=redirect_pc&~3:
  - REQ, not accepted same cycle: fetch_pc<=T, stay REQ.
  - REQ, accepted same cycle: fetch_pc<=T, drop<=1, ->WAIT.
  - WAIT, no rsp same cycle: fetch_pc<=T, drop<=1, stay WAIT.
  - WAIT, rsp same cycle: response discarded, fetch_pc<=T, drop<=0, ->REQ.
  - HOLD: held instruction squashed even if out_ready=1 (decode must not treat it as consumed), fetch_pc<=T, ->REQ.
  - Repeated redirects while dropping keep the latest T; only one stale response is ever discarded.
- imem_rsp_valid outside WAIT is ignored. imem_rsp_err only sets out_err; fetch continues normally.
- out_op is combinational from the holding register; no decode in this block.

## Timing
- Reset: state=REQ, fetch_pc=RESET_PC, drop=0, out_valid=0, out_pc=0, out_inst=0 (out_op=0), out_err=0. imem_req_valid=0 while rst=1; 1 in first cycle after rst deasserts, addr=RESET_PC.
- Reset mid-operation discards any outstanding request state; a response arriving after reset is ignored (state is REQ).
- All outputs are driven from registers (imem_req_addr=fetch_pc, valids decoded from state); no combinational path from any input to any output.
- Latency: request accepted at cycle t, response at t+k (k>=1), out_valid=1 at t+k+1.
- Decode handshake at cycle c -> next imem_req_valid at c+1. Best case throughput with 1-cycle memory: one instruction per 3 cycles.
- Redirect at cycle r in REQ/HOLD -> imem_req_addr=T at r+1.

## Test plan
- Reset then 1-cycle memory, out_ready=1: requests 0x80000000, 0x80000004, 0x80000008; out_pc matches, out_op=out_inst[6:0], each out_valid 2 cycles after accept.
- out_ready=0 for 5 cycles in HOLD: out_valid, out_pc, out_inst stable, imem_req_valid=0 throughout; release -> next addr=req_pc+4 one cycle later.
- Redirect to 0x80001002 during WAIT with 3-cycle memory: stale response dropped, out_valid never asserted for it, next request addr=0x80001000.
- Redirect in HOLD with out_ready=1 same cycle: instruction squashed, next addr=T; redirect coincident with rsp_valid in WAIT: response discarded, REQ next cycle with no extra drop.
- fetch_pc=0xFFFFFFFC consumed: next request addr=0x00000000. imem_rsp_err=1 -> out_err=1 for that instruction only.
- Assert rst during WAIT and during HOLD: out_valid=0 next cycle, fetch restarts at RESET_PC, late response ignored.
